sysid_regs: RTL and testbench

SYSID_REGS -- requirements
Module: sysid_regs

---
 rtl/sysid_regs.sv | 73 +++++++
 tb/tb_sysid_regs.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system ID, build timestamp, uptime counter and scratch registers
module sysid_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'h00000001,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          N_SCRATCH    = 2,
  parameter logic [31:0] SCRATCH_INIT = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);
  logic [63:0] uptime;
  logic [31:0] shadow;
  logic        en;
  logic [31:0] scratch [N_SCRATCH];
  logic [31:0] rd_mux;
  logic        rdv_q;
  logic        ctrl_wr;
  logic        clr;
  assign ctrl_wr = write && address == 4'd5 && byteenable[0];
  assign clr = ctrl_wr && writedata[1];
  assign readdatavalid = rdv_q & reset_n;
  // word map decode; unmapped addresses read as zero
  always_comb begin
    rd_mux = address == 4'd0 ? SYSTEM_ID :
             address == 4'd1 ? TIMESTAMP :
             address == 4'd2 ? {15'b0, 1'b1, 8'h02, 8'(N_SCRATCH)} :
             address == 4'd3 ? uptime[31:0] :
             address == 4'd4 ? shadow :
             address == 4'd5 ? {31'b0, en} : '0;
    for (int w = 0; w < N_SCRATCH; w++) if (address == 4'(6 + w)) rd_mux = scratch[w];
  end
  // registered read data with a one-cycle valid pulse; data holds between reads
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata <= '0;
      rdv_q <= 1'b0;
    end else begin
      rdv_q <= read;
      if (read) readdata <= rd_mux;
    end
  end
  // free-running uptime counter; a clear write wins over the increment
  always_ff @(posedge clock) begin
    if (!reset_n) uptime <= '0;
    else if (clr) uptime <= '0;
    else if (en) uptime <= uptime + 64'd1;
  end
  // high word snapshot taken whenever the low word is read, for a coherent 64-bit read
  always_ff @(posedge clock) begin
    if (!reset_n) shadow <= '0;
    else if (read && address == 4'd3) shadow <= uptime[63:32];
  end
  // counter enable bit
  always_ff @(posedge clock) begin
    if (!reset_n) en <= 1'b1;
    else if (ctrl_wr) en <= writedata[0];
  end
  // scratch words with per-byte write enables
  always_ff @(posedge clock) begin
    for (int w = 0; w < N_SCRATCH; w++) begin
      if (!reset_n) scratch[w] <= SCRATCH_INIT;
      else if (write && address == 4'(6 + w))
        for (int b = 0; b < 4; b++) if (byteenable[b]) scratch[w][8*b +: 8] <= writedata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: vector table, directed corner sequences and randomized model check for sysid_regs
module tb_sysid_regs;
  localparam logic [31:0] SID  = 32'hC0DE0042;
  localparam logic [31:0] TS   = 32'h65A1B2C3;
  localparam logic [31:0] INIT = 32'h12345678;
  localparam int NS = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] address = '0;
  logic read = 1'b0;
  logic write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0] byteenable = '0;
  logic [31:0] readdata;
  logic readdatavalid;
  int n_chk = 0;
  int n_fail = 0;
  bit use_model = 1'b1;
  logic [63:0] m_cnt;
  logic [31:0] m_sh;
  logic m_en;
  logic [31:0] m_scr [NS];
  logic [31:0] m_rd;
  logic m_v;
  typedef struct {
    logic rn, rd, wr;
    logic [3:0] a;
    logic [31:0] wd;
    logic [3:0] be;
    logic ev;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[$];

  sysid_regs #(.SYSTEM_ID(SID), .TIMESTAMP(TS), .N_SCRATCH(NS), .SCRATCH_INIT(INIT)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input logic [3:0] a);
    if (a == 4'd0) return SID;
    if (a == 4'd1) return TS;
    if (a == 4'd2) return {15'b0, 1'b1, 8'h02, 8'(NS)};
    if (a == 4'd3) return m_cnt[31:0];
    if (a == 4'd4) return m_sh;
    if (a == 4'd5) return {31'b0, m_en};
    if (int'(a) >= 6 && int'(a) < 6 + NS) return m_scr[int'(a) - 6];
    return '0;
  endfunction

  task automatic cyc(input logic rn, input logic rd, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    if (!rn) begin
      m_rd = '0; m_v = 1'b0; m_cnt = '0; m_sh = '0; m_en = 1'b1;
      for (int i = 0; i < NS; i++) m_scr[i] = INIT;
    end else begin
      m_v = rd;
      if (rd) m_rd = peek(a);
      if (rd && a == 4'd3) m_sh = m_cnt[63:32];
      if (wr && a == 4'd5 && be[0] && wd[1]) m_cnt = '0;
      else if (m_en) m_cnt = m_cnt + 64'd1;
      if (wr && a == 4'd5 && be[0]) m_en = wd[0];
      if (wr && int'(a) >= 6 && int'(a) < 6 + NS)
        for (int b = 0; b < 4; b++) if (be[b]) m_scr[int'(a) - 6][8*b +: 8] = wd[8*b +: 8];
    end
    reset_n = rn; read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    @(posedge clock);
    @(negedge clock);
    if (use_model) begin
      chk("model_rdv", 32'(readdatavalid), 32'(m_v));
      chk("model_rdata", readdata, m_rd);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    cyc(1, 1, 0, a, '0, '0);
    chk({nm, "_rdv"}, 32'(readdatavalid), 32'd1);
    chk(nm, readdata, exp);
  endtask

  initial begin
    tbl.push_back('{0, 0, 0, 4'd0,  32'h0,        4'h0, 0, 32'h0});
    tbl.push_back('{0, 1, 1, 4'd6,  32'hFFFFFFFF, 4'hF, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd0,  32'h0,        4'h0, 1, SID});
    tbl.push_back('{1, 1, 0, 4'd1,  32'h0,        4'h0, 1, TS});
    tbl.push_back('{1, 1, 0, 4'd2,  32'h0,        4'h0, 1, 32'h00010202});
    tbl.push_back('{1, 0, 1, 4'd6,  32'hA5A5A5A5, 4'h5, 0, 32'h00010202});
    tbl.push_back('{1, 1, 0, 4'd6,  32'h0,        4'h0, 1, 32'h12A556A5});
    tbl.push_back('{1, 1, 0, 4'd7,  32'h0,        4'h0, 1, INIT});
    tbl.push_back('{1, 1, 0, 4'd15, 32'h0,        4'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 1, 4'd0,  32'hFFFFFFFF, 4'hF, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd0,  32'h0,        4'h0, 1, SID});
    tbl.push_back('{1, 1, 0, 4'd5,  32'h0,        4'h0, 1, 32'h1});
    tbl.push_back('{1, 1, 1, 4'd7,  32'h0,        4'hF, 1, INIT});
    tbl.push_back('{1, 1, 0, 4'd7,  32'h0,        4'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 1, 4'd8,  32'hDEADBEEF, 4'hF, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd8,  32'h0,        4'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 1, 4'd5,  32'h0,        4'hF, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd5,  32'h0,        4'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 1, 4'd5,  32'h1,        4'h0, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd5,  32'h0,        4'h0, 1, 32'h0});
    tbl.push_back('{1, 0, 1, 4'd5,  32'h1,        4'h1, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 4'd5,  32'h0,        4'h0, 1, 32'h1});
    tbl.push_back('{1, 0, 1, 4'd1,  32'h0,        4'hF, 0, 32'h1});
    tbl.push_back('{1, 1, 0, 4'd1,  32'h0,        4'h0, 1, TS});
    @(negedge clock);
    foreach (tbl[i]) begin
      cyc(tbl[i].rn, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].be);
      chk($sformatf("tbl%0d_rdv", i), 32'(readdatavalid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_rdata", i), readdata, tbl[i].ed);
    end
    cyc(0, 0, 0, 4'd0, '0, '0);
    cyc(0, 0, 0, 4'd0, '0, '0);
    rd_chk("up_first", 4'd3, 32'd0);
    rd_chk("up_second", 4'd3, 32'd1);
    rd_chk("up_third", 4'd3, 32'd2);
    rd_chk("hi_small", 4'd4, 32'd0);
    cyc(1, 0, 1, 4'd5, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 4'd0, '0, '0);
    rd_chk("frozen_a", 4'd3, 32'd5);
    rd_chk("frozen_b", 4'd3, 32'd5);
    cyc(1, 0, 1, 4'd5, 32'h3, 4'hF);
    rd_chk("clr_zero", 4'd3, 32'd0);
    rd_chk("clr_one", 4'd3, 32'd1);
    rd_chk("ctrl_after_clr", 4'd5, 32'd1);
    cyc(1, 1, 0, 4'd0, '0, '0);
    reset_n = 1'b0; read = 1'b0;
    #1;
    chk("rdv_masked_by_reset", 32'(readdatavalid), 32'd0);
    cyc(0, 0, 0, 4'd0, '0, '0);
    chk("rdv_in_reset", 32'(readdatavalid), 32'd0);
    rd_chk("id_after_reset", 4'd0, SID);
    use_model = 1'b0;
    force dut.uptime = 64'h00000000_FFFFFFFF;
    rd_chk("lo_before_carry", 4'd3, 32'hFFFFFFFF);
    release dut.uptime;
    rd_chk("hi_is_shadow", 4'd4, 32'h0);
    cyc(1, 0, 0, 4'd0, '0, '0);
    cyc(1, 1, 0, 4'd3, '0, '0);
    rd_chk("hi_after_carry", 4'd4, 32'h1);
    use_model = 1'b1;
    cyc(0, 0, 0, 4'd0, '0, '0);
    cyc(0, 0, 0, 4'd0, '0, '0);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8)),
          $urandom, 4'($urandom_range(0, 15)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
